// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the execute-stage ALU and the sequential M-extension unit,
// plus small sign-handling helpers used by the multiply/divide fixup.
package muldiv_seq_pkg;

    localparam logic [3:0] alu_func_add  = 4'd0;
    localparam logic [3:0] alu_func_sub  = 4'd1;
    localparam logic [3:0] alu_func_sll  = 4'd2;
    localparam logic [3:0] alu_func_slt  = 4'd3;
    localparam logic [3:0] alu_func_sltu = 4'd4;
    localparam logic [3:0] alu_func_xor  = 4'd5;
    localparam logic [3:0] alu_func_srl  = 4'd6;
    localparam logic [3:0] alu_func_sra  = 4'd7;
    localparam logic [3:0] alu_func_or   = 4'd8;
    localparam logic [3:0] alu_func_and  = 4'd9;

    localparam logic [2:0] muldiv_op_mul    = 3'd0;
    localparam logic [2:0] muldiv_op_mulh   = 3'd1;
    localparam logic [2:0] muldiv_op_mulhsu = 3'd2;
    localparam logic [2:0] muldiv_op_mulhu  = 3'd3;
    localparam logic [2:0] muldiv_op_div    = 3'd4;
    localparam logic [2:0] muldiv_op_divu   = 3'd5;
    localparam logic [2:0] muldiv_op_rem    = 3'd6;
    localparam logic [2:0] muldiv_op_remu   = 3'd7;

    localparam logic [4:0] muldiv_last_step = 5'd31;

    typedef enum logic [1:0] {
        muldiv_st_idle = 2'd0,
        muldiv_st_busy = 2'd1,
        muldiv_st_done = 2'd2
    } muldiv_state_e;

    function automatic logic [31:0] neg_if32(input logic neg, input logic [31:0] val);
        return neg ? (32'd0 - val) : val;
    endfunction

    function automatic logic [63:0] neg_if64(input logic neg, input logic [63:0] val);
        return neg ? (64'd0 - val) : val;
    endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// One-bit-per-cycle iteration datapath: shift-add multiply on {hi,lo} or
// restoring shift-subtract divide (hi = partial remainder, lo = quotient).
module muldiv_iter_dp
    import muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a_abs,
    input  logic [31:0] b_abs,
    output logic [31:0] nxt_hi,
    output logic [31:0] nxt_lo
);

    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] opnd_r;

    logic [32:0] sum_s;
    logic [32:0] shifted_s;
    logic [31:0] diff_s;
    logic        ge_s;

    assign sum_s     = {1'b0, hi_r} + {1'b0, (lo_r[0] ? opnd_r : 32'd0)};
    assign shifted_s = {hi_r, lo_r[31]};
    assign ge_s      = (shifted_s >= {1'b0, opnd_r});
    // When ge_s holds the true difference is below the divisor, so 32 bits suffice.
    assign diff_s    = shifted_s[31:0] - opnd_r;

    // Value of the accumulator pair after the current iteration
    always_comb begin
        nxt_hi = hi_r;
        nxt_lo = lo_r;
        if (is_div) begin
            if (ge_s) begin
                nxt_hi = diff_s;
                nxt_lo = {lo_r[30:0], 1'b1};
            end else begin
                nxt_hi = shifted_s[31:0];
                nxt_lo = {lo_r[30:0], 1'b0};
            end
        end else begin
            nxt_hi = sum_s[32:1];
            nxt_lo = {sum_s[0], lo_r[31:1]};
        end
    end

    // Accumulator and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            opnd_r <= 32'd0;
        end else if (load) begin
            hi_r   <= 32'd0;
            lo_r   <= a_abs;
            opnd_r <= b_abs;
        end else if (step) begin
            hi_r   <= nxt_hi;
            lo_r   <= nxt_lo;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32 M-extension unit: FSM, step counter, handshakes and sign fixup.
// Optional MULDIV_DIV_BYPASS_EN retires divide-by-zero / signed overflow right after accept.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        busy
);

    muldiv_state_e state_r;
    logic [4:0]    count_r;
    logic          loaded_r;
    logic [2:0]    op_r;
    logic [31:0]   a_abs_r;
    logic [31:0]   b_abs_r;
    logic          res_neg_r;
    logic          div_zero_r;
    logic          resp_valid_r;
    logic          busy_r;
    logic [31:0]   resp_result_r;

    logic          accept_s;
    logic          a_signed_s;
    logic          b_signed_s;
    logic          a_neg_s;
    logic          b_neg_s;
    logic          res_neg_s;
    logic          div_zero_s;
    logic [31:0]   a_abs_s;
    logic [31:0]   b_abs_s;
    logic          dp_load_s;
    logic          dp_step_s;
    logic [31:0]   nxt_hi_s;
    logic [31:0]   nxt_lo_s;
    logic [63:0]   prod_fix_s;
    logic [31:0]   final_s;

    assign req_ready   = rst_n & ~flush & (state_r == muldiv_st_idle);
    assign accept_s    = req_valid & req_ready;
    assign resp_valid  = resp_valid_r;
    assign resp_result = resp_result_r;
    assign busy        = busy_r;

    // Operand signedness for the requested op
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (req_op)
            muldiv_op_mulh, muldiv_op_div, muldiv_op_rem: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            muldiv_op_mulhsu: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
    end

    assign a_neg_s    = a_signed_s & req_a[31];
    assign b_neg_s    = b_signed_s & req_b[31];
    assign a_abs_s    = neg_if32(a_neg_s, req_a);
    assign b_abs_s    = neg_if32(b_neg_s, req_b);
    // Remainders take the dividend's sign; products and quotients the xor of both.
    assign res_neg_s  = (req_op[2] & req_op[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
    assign div_zero_s = req_op[2] & (req_b == 32'd0);

    // The first BUSY cycle stages the latched magnitudes into the datapath.
    assign dp_load_s = (state_r == muldiv_st_busy) & ~loaded_r;
    assign dp_step_s = (state_r == muldiv_st_busy) & loaded_r;

    muldiv_iter_dp u_iter_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (dp_load_s),
        .step   (dp_step_s),
        .is_div (op_r[2]),
        .a_abs  (a_abs_r),
        .b_abs  (b_abs_r),
        .nxt_hi (nxt_hi_s),
        .nxt_lo (nxt_lo_s)
    );

    assign prod_fix_s = neg_if64(res_neg_r, {nxt_hi_s, nxt_lo_s});

    // Result selection with sign correction, taken from the final iteration
    always_comb begin
        final_s = 32'd0;
        case (op_r)
            muldiv_op_mul: begin
                final_s = prod_fix_s[31:0];
            end
            muldiv_op_mulh, muldiv_op_mulhsu, muldiv_op_mulhu: begin
                final_s = prod_fix_s[63:32];
            end
            muldiv_op_div, muldiv_op_divu: begin
                final_s = div_zero_r ? 32'hFFFF_FFFF : neg_if32(res_neg_r, nxt_lo_s);
            end
            muldiv_op_rem, muldiv_op_remu: begin
                final_s = neg_if32(res_neg_r, nxt_hi_s);
            end
            default: begin
                final_s = 32'd0;
            end
        endcase
    end

`ifdef MULDIV_DIV_BYPASS_EN
    logic        ovf_s;
    logic        bypass_s;
    logic [31:0] bypass_res_s;

    assign ovf_s = req_op[2] & ~req_op[0] & (req_a == 32'h8000_0000) & (req_b == 32'hFFFF_FFFF);

    // Architecturally fixed results for the two divide corner cases
    always_comb begin
        bypass_s     = 1'b0;
        bypass_res_s = 32'd0;
        if (div_zero_s) begin
            bypass_s     = 1'b1;
            bypass_res_s = req_op[1] ? req_a : 32'hFFFF_FFFF;
        end else if (ovf_s) begin
            bypass_s     = 1'b1;
            bypass_res_s = req_op[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            bypass_s     = 1'b0;
            bypass_res_s = 32'd0;
        end
    end
`endif

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= muldiv_st_idle;
            count_r       <= 5'd0;
            loaded_r      <= 1'b0;
            op_r          <= 3'd0;
            a_abs_r       <= 32'd0;
            b_abs_r       <= 32'd0;
            res_neg_r     <= 1'b0;
            div_zero_r    <= 1'b0;
            resp_valid_r  <= 1'b0;
            busy_r        <= 1'b0;
            resp_result_r <= 32'd0;
        end else begin
            case (state_r)
                muldiv_st_idle: begin
                    if (accept_s) begin
                        op_r       <= req_op;
                        a_abs_r    <= a_abs_s;
                        b_abs_r    <= b_abs_s;
                        res_neg_r  <= res_neg_s;
                        div_zero_r <= div_zero_s;
                        count_r    <= 5'd0;
                        loaded_r   <= 1'b0;
                        busy_r     <= 1'b1;
`ifdef MULDIV_DIV_BYPASS_EN
                        if (bypass_s) begin
                            state_r       <= muldiv_st_done;
                            resp_valid_r  <= 1'b1;
                            resp_result_r <= bypass_res_s;
                        end else begin
                            state_r       <= muldiv_st_busy;
                        end
`else
                        state_r    <= muldiv_st_busy;
`endif
                    end
                end
                muldiv_st_busy: begin
                    if (flush) begin
                        state_r <= muldiv_st_idle;
                        busy_r  <= 1'b0;
                    end else if (!loaded_r) begin
                        loaded_r <= 1'b1;
                    end else begin
                        count_r <= count_r + 5'd1;
                        if (count_r == muldiv_last_step) begin
                            state_r       <= muldiv_st_done;
                            resp_valid_r  <= 1'b1;
                            resp_result_r <= final_s;
                        end
                    end
                end
                muldiv_st_done: begin
                    if (flush || resp_ready) begin
                        state_r      <= muldiv_st_idle;
                        resp_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= muldiv_st_idle;
                    resp_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed corner cases plus randomized ops
// against an arithmetic reference model; a monitor checks results and latency.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic        busy;

    muldiv_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .flush       (flush),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        logic [2:0]  op;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   rr_low = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int qa, qb;
        bit ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        qa  = $signed(a);
        qb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(qa / qb);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                return 32'(qa % qb);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_BYPASS_EN
        if (op[2] && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
        if (op == 3'd7 && a == 32'd0 && b == 32'd0) return 33;
        return 33;
    endfunction

    // Consumer: random back-pressure unless forced low
    initial begin
        forever begin
            @(posedge clk);
            #1 resp_ready = rr_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on first valid, stability while held, result on handshake
    initial begin
        bit          seen = 1'b0;
        bit          hold_v = 1'b0;
        logic [31:0] held = 32'd0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen   = 1'b0;
                hold_v = 1'b0;
            end else begin
                if (resp_valid && !seen) begin
                    if (exp_q.size() == 0) chk("unexpected_resp", 32'(resp_valid), 32'd0);
                    else chk("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
                end
                if (hold_v) chk("hold_stable", resp_result, held);
                if (resp_valid && resp_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("result_op%0d", e.op), resp_result, e.res);
                end
                hold_v = resp_valid && !resp_ready;
                held   = resp_result;
                seen   = resp_valid;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input bit push);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        if (push) exp_q.push_back('{res: res, acc: cyc + 1, lat: ref_lat(op, a, b), op: op});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || busy) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [2:0]  op;
        logic [31:0] a, b;

        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("req_ready_after_rst", 32'(req_ready), 32'd1);

        send(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        send(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        send(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        send(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
        send(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
        send(3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1);
        send(3'd7, 32'd100, 32'd0, 32'd100, 1'b1);
        send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
        send(3'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1);
        send(3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1);
        wait_drain();

        // Back-pressure: result must hold while the consumer stalls
        rr_low = 1'b1;
        send(3'd0, 32'd12345, 32'd1000, 32'd12345000, 1'b1);
        n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_resp_valid", 32'(resp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_valid_held", 32'(resp_valid), 32'd1);
        end
        rr_low = 1'b0;
        wait_drain();

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = 3'd0;
        #1 chk("req_ready_flush_idle", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("no_accept_flush_idle", 32'(busy), 32'd0);
        flush     = 1'b0;
        req_valid = 1'b0;

        // Flush in BUSY at accept+10
        send(3'd0, 32'd3, 32'd5, 32'd15, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_busy_low", 32'(busy), 32'd0);
        chk("flush_resp_valid", 32'(resp_valid), 32'd0);
        chk("flush_req_ready", 32'(req_ready), 32'd1);
        send(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1);
        wait_drain();

        // Randomized operations with biased corner operands
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin
                    a = 32'($urandom_range(0, 20));
                    b = 32'($urandom_range(1, 7));
                    if ($urandom_range(0, 1) == 1) a = 32'd0 - a;
                    if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
                end
                default: ;
            endcase
            send(op, a, b, ref_model(op, a, b), 1'b1);
        end
        wait_drain();

        // Reset in the middle of an operation
        send(3'd0, 32'd5, 32'd5, 32'd25, 1'b1);
        wait_drain();
        send(3'd0, 32'd9, 32'd9, 32'd81, 1'b1);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_resp_result", resp_result, 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("req_ready_after_midrst", 32'(req_ready), 32'd1);
        send(3'd5, 32'd1000, 32'd7, 32'd142, 1'b1);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port req_valid, input, 1 bit: execute stage presents an M-extension operation.
REQ-004 SHALL have port req_ready, output, 1 bit: high only in IDLE with flush low.
REQ-005 SHALL have port req_op, input, 3 bits: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
REQ-006 SHALL have ports req_a and req_b, input, 32 bits each: operands rs1 and rs2.
REQ-007 SHALL have port flush, input, 1 bit: pipeline redirect; kills the in-flight operation.
REQ-008 SHALL have port resp_valid, output, 1 bit: result is available (DONE state).
REQ-009 SHALL have port resp_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port resp_result, output, 32 bits: final result, held stable while resp_valid is high.
REQ-011 SHALL have port busy, output, 1 bit: stall request to the execute stage, high in BUSY or in DONE.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 SHALL accept a request when req_valid and req_ready are both high: latch op, operand absolute values and result-sign flags, clear the 5-bit counter, move to BUSY.
REQ-014 SHALL treat operands as signed for mulh and div/rem, and mulhsu as a signed, b unsigned.
REQ-015 SHALL in BUSY perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, incrementing the counter.
REQ-016 SHALL leave BUSY when count equals 31, apply sign correction on that edge and enter DONE; resp_valid is first high exactly 33 cycles after the accept edge.
REQ-017 SHALL select the result as: mul returns product[31:0]; mulh/mulhsu/mulhu return product[63:32]; div/divu return the quotient; rem/remu return the remainder, whose sign follows the dividend.
REQ-018 SHALL, on divide by zero, return 0xFFFFFFFF as quotient and req_a as remainder.
REQ-019 SHALL, on signed overflow (0x80000000 / 0xFFFFFFFF), return 0x80000000 as quotient and 0 as remainder.
REQ-020 SHALL in DONE go to IDLE on resp_valid and resp_ready; otherwise it holds the result (back-pressure).
REQ-021 SHALL never accept a request in the cycle of response retirement; the next accept is possible at the earliest one cycle later.
REQ-022 SHALL, on flush in BUSY or DONE, go to IDLE on the next edge with resp_valid low and no response produced.
REQ-023 SHALL, when flush and req_valid are both high in IDLE, not accept the request.
REQ-024 SHALL keep resp_result unchanged except on the entry edge into DONE.

Reset
REQ-025 SHALL on rst_n low immediately force: state IDLE, counter 0, resp_valid 0, busy 0, resp_result 0, all operand and accumulator registers 0.
REQ-026 SHALL, if reset is asserted mid-operation, discard the operation; after release, req_ready is high in the first cycle.

Configuration
REQ-027 SHALL, with macro MULDIV_DIV_BYPASS_EN defined, send divide-by-zero and signed-overflow requests from IDLE directly to DONE, with resp_valid high in the cycle after accept.
REQ-028 SHALL, without MULDIV_DIV_BYPASS_EN, run those cases through the full 32 iterations, producing identical values at 33-cycle latency.

Structure
REQ-029 SHALL take op encodings (muldiv_op_*) and FSM state encodings from the shared define header, beside the alu_func_* encodings.
REQ-030 SHALL place the per-step shift-add/shift-subtract datapath in sub-module muldiv_iter_dp; muldiv_seq holds the FSM, counter, handshakes and sign fixup.

Verification
REQ-031 SHALL cover: mul 7 x -3 -> resp_valid at accept+33, resp_result 0xFFFFFFEB.
REQ-032 SHALL cover: mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; mulh of the same operands -> 0x00000000.
REQ-033 SHALL cover: div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; divu 100/0 -> 0xFFFFFFFF; remu 100/0 -> 100. With MULDIV_DIV_BYPASS_EN, the /0 cases complete at accept+1.
REQ-034 SHALL cover: div 0x80000000/0xFFFFFFFF -> 0x80000000; rem of the same operands -> 0.
REQ-035 SHALL cover: flush at accept+10 -> IDLE next cycle, no resp_valid ever; a new request accepted immediately afterwards completes correctly.
REQ-036 SHALL cover back-pressure and reset: resp_ready held low 5 cycles -> resp_result stable and busy high; rst_n pulsed low mid-BUSY -> all outputs 0 at once, req_ready high after release.
